// File: rtl/switch_poll_pkg.sv
// Shared types and helpers for the switch polling controller.
package switch_poll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPT
  } poll_state_t;

  localparam logic [1:0] PIO_DATA_OFFSET = 2'd0;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value == max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/switch_poll_tick_gen.sv
// Poll timer: emits a one-cycle tick every POLL_DIV enabled cycles.
module poll_tick_gen #(
  parameter int POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(POLL_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(POLL_DIV - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= RELOAD;
    end else if (!enable || count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - 1'b1;
    end
  end

  assign tick = enable && (count == '0);

endmodule

// File: rtl/switch_poll_ctrl.sv
// Avalon-MM master that polls the switches PIO and reports value changes
// as events on a valid/ready port with a level interrupt.
module switch_poll_ctrl
  import switch_poll_pkg::*;
#(
  parameter int POLL_DIV = 50000,
  parameter int DATA_W   = 4,
  parameter int DROP_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_data,
  output logic [DATA_W-1:0] evt_changed,
  output logic              irq,
  output logic [DROP_W-1:0] drop_cnt
);

  logic              tick;
  poll_state_t       state;
  logic              baseline_vld;
  logic [DATA_W-1:0] last;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] diff;
  logic              accept;
  logic              unused_readdata;

  poll_tick_gen #(
    .POLL_DIV(POLL_DIV)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (tick)
  );

  assign sample          = avm_readdata[DATA_W-1:0];
  assign unused_readdata = ^avm_readdata[31:DATA_W];
  assign diff            = sample ^ last;
  assign accept          = evt_valid & evt_ready;
  assign avm_address     = PIO_DATA_OFFSET;
  assign irq             = evt_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      avm_read     <= 1'b0;
      baseline_vld <= 1'b0;
      last         <= '0;
      evt_valid    <= 1'b0;
      evt_data     <= '0;
      evt_changed  <= '0;
      drop_cnt     <= '0;
    end else begin
      avm_read <= 1'b0;

      // A capture below overrides this clear, so accept-and-reload in the
      // same cycle leaves the slot full with only the new change bits.
      if (accept) begin
        evt_valid   <= 1'b0;
        evt_changed <= '0;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            avm_read <= 1'b1;
            state    <= READ;
          end
        end
        READ: state <= CAPT;
        CAPT: begin
          state <= IDLE;
          if (!baseline_vld) begin
            last         <= sample;
            baseline_vld <= 1'b1;
          end else if (sample != last) begin
            last     <= sample;
            evt_data <= sample;
            if (!evt_valid || evt_ready) begin
              evt_changed <= diff;
              evt_valid   <= 1'b1;
            end else begin
              evt_changed <= evt_changed | diff;
              drop_cnt    <= DROP_W'(sat_inc(32'(drop_cnt), 32'({DROP_W{1'b1}})));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_poll_ctrl.sv
// Directed bench for switch_poll_ctrl with a queue scoreboard of expected events.
module tb_switch_poll_ctrl;

  localparam int POLL_DIV = 4;
  localparam int DATA_W   = 4;
  localparam int DROP_W   = 8;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] changed;
    logic [DROP_W-1:0] drop;
  } evt_t;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic [1:0]        avm_address;
  logic              avm_read;
  logic [31:0]       avm_readdata;
  logic              evt_valid;
  logic              evt_ready;
  logic [DATA_W-1:0] evt_data;
  logic [DATA_W-1:0] evt_changed;
  logic              irq;
  logic [DROP_W-1:0] drop_cnt;
  logic [DATA_W-1:0] switches;

  int checks   = 0;
  int failures = 0;

  evt_t              q[$];
  bit                m_base;
  logic [DATA_W-1:0] m_last;
  logic [DATA_W-1:0] m_data;
  logic [DROP_W-1:0] m_drop;

  switch_poll_ctrl #(
    .POLL_DIV(POLL_DIV),
    .DATA_W  (DATA_W),
    .DROP_W  (DROP_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .avm_address (avm_address),
    .avm_read    (avm_read),
    .avm_readdata(avm_readdata),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_data    (evt_data),
    .evt_changed (evt_changed),
    .irq         (irq),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PIO slave: registered readdata, junk upper bits, junk when not read.
  always @(posedge clk) begin
    avm_readdata <= avm_read ? {28'hABCDE12, switches} : 32'hFFFF_FFF0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_avm_read"}, avm_read, 0);
    check({tag, "_avm_address"}, avm_address, 0);
    check({tag, "_evt_valid"}, evt_valid, 0);
    check({tag, "_evt_data"}, evt_data, 0);
    check({tag, "_evt_changed"}, evt_changed, 0);
    check({tag, "_irq"}, irq, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_evt_valid"}, evt_valid, q.size() != 0);
    check({tag, "_irq"}, irq, q.size() != 0);
    check({tag, "_drop_cnt"}, drop_cnt, m_drop);
    check({tag, "_evt_data"}, evt_data, m_data);
    if (q.size() != 0) check({tag, "_evt_changed"}, evt_changed, q[0].changed);
    else               check({tag, "_evt_changed"}, evt_changed, 0);
  endtask

  // Returns negedges waited until avm_read is seen, or -1 on timeout.
  task automatic wait_read(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!avm_read && n < 16);
    if (!avm_read) n = -1;
    else check("read_address", avm_address, 0);
  endtask

  task automatic pop_compare(input string tag);
    evt_t e;
    check({tag, "_valid"}, evt_valid, 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      check({tag, "_data"}, evt_data, e.data);
      check({tag, "_changed"}, evt_changed, e.changed);
      check({tag, "_drop"}, drop_cnt, e.drop);
    end
  endtask

  task automatic accept_evt(input string tag);
    pop_compare(tag);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    check_state({tag, "_after"});
  endtask

  // Presents a new switch value, lets one poll sample it and updates the model.
  task automatic do_poll(input string tag, input logic [DATA_W-1:0] sw_new, input bit accept_at_capt);
    int n;
    bit was_pending;
    switches = sw_new;
    wait_read(n);
    check({tag, "_read_timeout"}, n < 0, 0);
    was_pending = (q.size() != 0);
    @(negedge clk);
    check({tag, "_read_width"}, avm_read, 0);
    check({tag, "_valid_pre"}, evt_valid, was_pending);
    if (accept_at_capt) begin
      pop_compare({tag, "_acc"});
      evt_ready = 1'b1;
    end
    @(negedge clk);
    evt_ready = 1'b0;
    if (!m_base) begin
      m_base = 1'b1;
      m_last = sw_new;
    end else if (sw_new != m_last) begin
      if (q.size() == 0) begin
        q.push_back('{sw_new, sw_new ^ m_last, m_drop});
      end else begin
        m_drop = (m_drop == {DROP_W{1'b1}}) ? m_drop : m_drop + 1'b1;
        q[q.size()-1].data    = sw_new;
        q[q.size()-1].changed = q[q.size()-1].changed | (sw_new ^ m_last);
        q[q.size()-1].drop    = m_drop;
      end
      m_data = sw_new;
      m_last = sw_new;
    end
    check_state(tag);
  endtask

  initial begin
    int n;
    int reads;
    reset_n   = 1'b0;
    enable    = 1'b1;
    evt_ready = 1'b0;
    switches  = 4'h5;
    m_base    = 1'b0;
    m_last    = '0;
    m_data    = '0;
    m_drop    = '0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Test 1: steady polling, first sample is baseline only.
    for (int i = 0; i < 5; i++) begin
      wait_read(n);
      check("t1_read_period", n, 4);
    end
    m_base = 1'b1;
    m_last = 4'h5;
    repeat (2) @(negedge clk);
    check_state("t1_baseline");

    // Test 2: single change, then accept.
    do_poll("t2_change", 4'hC, 1'b0);
    accept_evt("t2_accept");

    // Test 3: two changes merged while the consumer stalls.
    do_poll("t3_5", 4'h5, 1'b0);
    accept_evt("t3_acc5");
    do_poll("t3_7", 4'h7, 1'b0);
    do_poll("t3_6", 4'h6, 1'b0);
    accept_evt("t3_acc6");

    // Test 4: accept coincides with a new change.
    do_poll("t4_c", 4'hC, 1'b0);
    do_poll("t4_d", 4'hD, 1'b1);

    // Test 5: enable low freezes polling.
    enable = 1'b0;
    reads  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (avm_read) reads++;
    end
    check("t5_no_reads", reads, 0);
    enable = 1'b1;
    wait_read(n);
    check("t5_reenable_latency", n, 4);
    repeat (2) @(negedge clk);
    check_state("t5_hold");

    // Test 6: reset during READ, baseline re-taken, drop counter saturates.
    wait_read(n);
    check("t6_read_seen", n > 0, 1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("t6_async_reset");
    q.delete();
    m_base = 1'b0;
    m_last = '0;
    m_data = '0;
    m_drop = '0;
    @(negedge clk);
    reset_n = 1'b1;
    do_poll("t6_baseline", 4'hA, 1'b0);
    for (int i = 0; i < (1 << DROP_W) + 4; i++) begin
      do_poll("t6_merge", (i % 2 == 0) ? 4'hC : 4'h3, 1'b0);
    end
    check("t6_drop_saturated", drop_cnt, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
